// File: rtl/button_conditioner.sv
// button_conditioner: turns the raw minute/hour push-buttons into clean,
// clock-synchronous single-cycle advance strobes. Each button has its own
// synchroniser, debouncer and press/auto-repeat FSM. The two channels share
// no state.

module button_channel #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 20000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse,
    output logic level
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX) + 1;

    localparam logic [DW-1:0] D_LAST     = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT
    } state_t;

    logic          s1;
    logic          s2;
    logic          stable;
    logic          stable_d;
    logic [DW-1:0] dcnt;

    state_t        state;
    state_t        state_n;
    logic [RW-1:0] rcnt;
    logic [RW-1:0] rcnt_n;
    logic          pulse_n;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Debounce: accept a new level only after it has held for the full
    // window; any return to the current level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 1'b0;
            dcnt   <= '0;
        end else if (s2 == stable) begin
            dcnt <= '0;
        end else if (dcnt == D_LAST) begin
            stable <= s2;
            dcnt   <= '0;
        end else begin
            dcnt <= dcnt + DW'(1);
        end
    end

    // FSM state, repeat counter, registered pulse and edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            rcnt     <= '0;
            pulse    <= 1'b0;
            stable_d <= 1'b0;
        end else begin
            state    <= state_n;
            rcnt     <= rcnt_n;
            pulse    <= pulse_n;
            stable_d <= stable;
        end
    end

    // Next state: press pulse on the debounced rising edge, first repeat
    // after the delay, then periodic repeats; release always wins.
    always_comb begin
        state_n = state;
        rcnt_n  = rcnt;
        pulse_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (stable && !stable_d) begin
                    pulse_n = 1'b1;
                    rcnt_n  = '0;
                    state_n = S_DELAY;
                end
            end
            S_DELAY: begin
                if (!stable) begin
                    state_n = S_IDLE;
                end else if (rcnt == DELAY_LAST) begin
                    pulse_n = 1'b1;
                    rcnt_n  = '0;
                    state_n = S_REPEAT;
                end else begin
                    rcnt_n = rcnt + RW'(1);
                end
            end
            S_REPEAT: begin
                if (!stable) begin
                    state_n = S_IDLE;
                end else if (rcnt == RATE_LAST) begin
                    pulse_n = 1'b1;
                    rcnt_n  = '0;
                end else begin
                    rcnt_n = rcnt + RW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                rcnt_n  = '0;
            end
        endcase
    end

    assign level = stable;

endmodule

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 20000000
) (
    input  logic clk,
    input  logic rst,
    input  logic minplus_raw,
    input  logic hrplus_raw,
    output logic min_pulse,
    output logic hr_pulse,
    output logic min_level,
    output logic hr_level
);

    button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
    ) u_min (
        .clk  (clk),
        .rst  (rst),
        .raw  (minplus_raw),
        .pulse(min_pulse),
        .level(min_level)
    );

    button_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
    ) u_hr (
        .clk  (clk),
        .rst  (rst),
        .raw  (hrplus_raw),
        .pulse(hr_pulse),
        .level(hr_level)
    );

endmodule
